kyber_ntt_out_reorder: RTL and testbench
========================================

Name: kyber_ntt_out_reorder

Overview:
- Consumer stage directly downstream of the KyberHPM1PE core's 12-bit dout port.
- After a read_a or read_b pulse, the core streams 256 coefficients in interleaved order 0,2,1,3,4,6,5,7,...
- This block captures that burst into a 256x12 buffer, un-permutes it, and re-emits the coefficients in natural order 0..255 over a valid/ready stream.
- It decouples the core's fixed-rate unload from a back-pressuring consumer (host interface or hash/pack logic).

Parameters:
- RD_LAT, 3: cycles from the read_start sample edge to the first valid coefficient on core_dout.
- N, 256: coefficients per polynomial. Fixed; the index width is 8.
- W, 12: coefficient width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- read_start  input  1  one-cycle pulse, issued in the same cycle as read_a/read_b to the core
- core_dout  input  W  coefficient stream from core dout
- out_data  output  W  natural-order coefficient
- out_idx  output  8  index of out_data (0..255)
- out_valid  output  1  out_data/out_idx valid
- out_last  output  1  high with out_valid when out_idx==255
- out_ready  input  1  consumer accepts when out_valid && out_ready
- busy  output  1  high in any state other than IDLE
- range_err  output  1  sticky; set if any captured coefficient >= 3329; cleared on the next accepted read_start
- start_err  output  1  one-cycle pulse when read_start arrives while busy
- done  output  1  one-cycle pulse in the cycle after the transfer with out_last

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs are 0: out_data, out_idx, out_valid, out_last, busy, range_err, start_err, done. Counters are 0. Buffer contents are don't-care.
- FSM states: IDLE, WAIT, CAPTURE, DRAIN.
- IDLE:
  - read_start=1 -> WAIT. The wait counter loads RD_LAT-1 and range_err clears.
  - If RD_LAT==1, go directly to CAPTURE.
- WAIT: decrement each cycle; at 0 -> CAPTURE. No core_dout sampling in WAIT.
- Capture timing: the first coefficient is sampled exactly RD_LAT clock edges after the edge that sampled read_start.
- CAPTURE:
  - Sample core_dout every cycle; arrival counter i runs 0..255.
  - Write address = {i[7:2], i[0], i[1]}, i.e. i[1] and i[0] swapped, so arrival order 0,2,1,3 lands at addresses 0,1,2,3 of natural order.
  - range_err sets if a sampled value >= 3329.
  - After i==255 is written -> DRAIN. No stalls are allowed: the core cannot be back-pressured.
- DRAIN:
  - Read pointer r runs 0..255; the buffer is read synchronously (one-cycle read latency).
  - A one-entry output register plus prefetch guarantees full throughput: with out_ready held high, one transfer occurs per cycle.
  - First out_valid occurs no later than 2 cycles after entering DRAIN.
  - While out_valid && !out_ready, out_data, out_idx and out_last hold stable. out_valid never drops without a transfer.
  - out_idx equals the natural coefficient index.
  - On the transfer with out_last=1: out_valid falls next cycle, done pulses for 1 cycle, state -> IDLE.
- read_start while busy (WAIT/CAPTURE/DRAIN): ignored; start_err pulses 1 cycle; the current operation is unaffected.
- read_start in the same cycle as done: accepted, because the state is already IDLE. done and the new start both proceed.
- Reset asserted mid-CAPTURE or mid-DRAIN: immediate return to IDLE with outputs zeroed; partial data is discarded.
- Latency (burst): read_start to first out_valid ≤ RD_LAT+256+2 cycles. Full drain with out_ready=1 takes 256 cycles.

Test Plan:
- Ramp: core_dout = arrival permutation of 0..255 (0,2,1,3,4,6,...), starting 3 cycles after read_start; out_ready=1 -> out_data=0..255 in order, out_idx==out_data, out_last only at 255, done pulses once, exactly 256 transfers in 256 consecutive cycles.
- Back-pressure: same data, out_ready random (≈50%) -> identical ordered sequence; out_data stable across every stalled cycle; no duplicates or drops.
- Range check: arrival word 5 = 0xD01 (3329), others < 3329 -> range_err=1 after capture and stays 1 through DRAIN; next read_start clears it to 0.
- Busy restart: read_start pulse at cycle 100 of CAPTURE -> start_err single pulse; output stream still the original 0..255.
- Back-to-back: read_start in the done cycle with a second burst of values 255..0 (natural order) -> second stream correct; no gap corruption.
- Mid-operation reset: assert reset at drain transfer 40 -> busy=0, out_valid=0 asynchronously; a subsequent normal burst yields a correct 0..255 stream.

Source files
------------

// File: rtl/kyber_ntt_out_reorder_if.sv
// Natural-order coefficient stream leaving the NTT output reorder buffer.
// The master drives the data and the slave applies back-pressure with out_ready.
interface kyber_ntt_out_reorder_if #(
   parameter int W = 12
);
   logic [W-1:0] out_data;
   logic [7:0]   out_idx;
   logic         out_valid;
   logic         out_last;
   logic         out_ready;

   modport master (
      output out_data,
      output out_idx,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_idx,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/kyber_ntt_out_reorder.sv
// Captures one interleaved 256-coefficient unload burst from the NTT core and
// replays it in natural order over a back-pressured valid/ready stream.
module kyber_ntt_out_reorder #(
   parameter int RD_LAT = 3,
   parameter int N      = 256,
   parameter int W      = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         read_start,
   input  logic [W-1:0]                 core_dout,
   kyber_ntt_out_reorder_if.master      out_if,
   output logic                         busy,
   output logic                         range_err,
   output logic                         start_err,
   output logic                         done
);
   localparam int           IW      = 8;
   localparam logic [W-1:0] KYBER_Q = W'(3329);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

   state_t         state, state_nxt;
   logic [7:0]     wait_cnt;
   logic [IW-1:0]  cap_cnt;
   logic [IW-1:0]  cap_addr;
   logic [IW:0]    rd_cnt;
   logic [W-1:0]   mem [N];

   logic [W-1:0]   rd_data_p1;
   logic [IW-1:0]  rd_idx_p1;
   logic           rd_vld_p1;
   logic [W-1:0]   out_data_p2;
   logic [IW-1:0]  out_idx_p2;
   logic           out_valid_p2;
   logic           out_last_p2;

   logic           cap_we, rd_re, load_out, out_fire;

   function automatic logic out_of_range(input logic [W-1:0] coef);
      return coef >= KYBER_Q;
   endfunction

   // Arrival order 0,2,1,3 within each group of four: swapping i[1:0] restores natural order.
   assign cap_addr = {cap_cnt[7:2], cap_cnt[0], cap_cnt[1]};
   assign out_fire = out_valid_p2 && out_if.out_ready;
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      cap_we    = 1'b0;
      rd_re     = 1'b0;
      load_out  = 1'b0;
      case (state)
         S_IDLE: begin
            if (read_start) state_nxt = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt <= 8'd1) state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            cap_we = 1'b1;
            if (cap_cnt == 8'(N - 1)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // The prefetch entry refills whenever it is empty or being moved into the output slot.
            load_out = rd_vld_p1 && (!out_valid_p2 || out_if.out_ready);
            rd_re    = !rd_cnt[IW] && (!rd_vld_p1 || load_out);
            if (out_fire && out_last_p2) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         cap_cnt      <= '0;
         rd_cnt       <= '0;
         rd_idx_p1    <= '0;
         rd_vld_p1    <= 1'b0;
         out_data_p2  <= '0;
         out_idx_p2   <= '0;
         out_valid_p2 <= 1'b0;
         out_last_p2  <= 1'b0;
         range_err    <= 1'b0;
         start_err    <= 1'b0;
         done         <= 1'b0;
      end else begin
         state     <= state_nxt;
         start_err <= read_start && (state != S_IDLE);
         done      <= out_fire && out_last_p2;
         case (state)
            S_IDLE: begin
               if (read_start) begin
                  wait_cnt  <= 8'(RD_LAT - 1);
                  range_err <= 1'b0;
                  cap_cnt   <= '0;
                  rd_cnt    <= '0;
               end
            end
            S_WAIT:    wait_cnt <= wait_cnt - 8'd1;
            S_CAPTURE: begin
               cap_cnt <= cap_cnt + 8'd1;
               if (out_of_range(core_dout)) range_err <= 1'b1;
            end
            default: ;
         endcase
         // p1: synchronous buffer read into the prefetch entry
         if (rd_re) begin
            rd_cnt    <= rd_cnt + 9'd1;
            rd_idx_p1 <= rd_cnt[IW-1:0];
            rd_vld_p1 <= 1'b1;
         end else if (load_out) begin
            rd_vld_p1 <= 1'b0;
         end
         // p2: output register, held while the consumer stalls
         if (load_out) begin
            out_valid_p2 <= 1'b1;
            out_data_p2  <= rd_data_p1;
            out_idx_p2   <= rd_idx_p1;
            out_last_p2  <= (rd_idx_p1 == 8'(N - 1));
         end else if (out_fire) begin
            out_valid_p2 <= 1'b0;
            out_last_p2  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_we) mem[cap_addr] <= core_dout;
      if (rd_re)  rd_data_p1   <= mem[rd_cnt[IW-1:0]];
   end

   assign out_if.out_data  = out_data_p2;
   assign out_if.out_idx   = out_idx_p2;
   assign out_if.out_valid = out_valid_p2;
   assign out_if.out_last  = out_last_p2;
endmodule

// File: tb/tb_kyber_ntt_out_reorder.sv
// Bench for the NTT output reorder buffer: emulates the core's interleaved unload
// and a randomly stalling consumer, checking against the natural-order source array.
module tb_kyber_ntt_out_reorder;
   logic        clk = 1'b0;
   logic        reset;
   logic        read_start;
   logic [11:0] core_dout;
   logic        busy, range_err, start_err, done;

   kyber_ntt_out_reorder_if #(.W(12)) oif ();

   kyber_ntt_out_reorder #(.RD_LAT(3), .N(256), .W(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .read_start (read_start),
      .core_dout  (core_dout),
      .out_if     (oif),
      .busy       (busy),
      .range_err  (range_err),
      .start_err  (start_err),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int nat [256];
   int ord [4] = '{0, 2, 1, 3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      read_start = 1'b0;
      oif.out_ready = 1'b1;
      @(negedge clk);
      check("done_single_pulse", done, 0);
      repeat (n) @(negedge clk);
   endtask

   // Runs one burst starting at the current negedge (read_start goes high now).
   // Returns on the negedge where done is seen, so a following call restarts in the done cycle.
   task automatic burst(input int ready_pct, input int restart_c, input int reset_at, input bit exp_range);
      int arr [256];
      int nx = 0, first_c = -1, last_c = -1, se_cnt = 0;
      bit fin = 0, prev_stall = 0;
      logic [11:0] pd;
      logic [7:0]  pi;
      logic        pl;
      for (int k = 0; k < 256; k++) arr[k] = nat[(k / 4) * 4 + ord[k % 4]];
      for (int c = 0; c < 4000 && !fin; c++) begin
         if (c > 0) begin
            if (c == 1) begin
               check("busy_after_start", busy, 1);
               check("range_err_cleared", range_err, 0);
            end
            if (start_err) se_cnt++;
            if (restart_c >= 0 && c == restart_c + 1) check("start_err_pulse", start_err, 1);
            if (prev_stall) begin
               check("stall_valid", oif.out_valid, 1);
               check("stall_data", oif.out_data, pd);
               check("stall_idx", oif.out_idx, pi);
               check("stall_last", oif.out_last, pl);
            end
            if (done) begin
               check("xfer_count", nx, 256);
               check("valid_after_last", oif.out_valid, 0);
               check("busy_after_done", busy, 0);
               check("start_err_count", se_cnt, (restart_c >= 0) ? 1 : 0);
               if (ready_pct == 100) begin
                  check("first_valid_latency", (first_c <= 261) ? 1 : 0, 1);
                  check("throughput", last_c - first_c, 255);
               end
               fin = 1;
            end
         end
         if (!fin) begin
            read_start = (c == 0) || (c == restart_c);
            core_dout  = (c >= 3 && c < 259) ? 12'(arr[c - 3]) : 12'($urandom_range(0, 4095));
            oif.out_ready = ($urandom_range(1, 100) <= ready_pct);
            if (reset_at >= 0 && nx == reset_at && oif.out_valid) begin
               reset = 1'b1;
               #1;
               check("reset_busy", busy, 0);
               check("reset_valid", oif.out_valid, 0);
               check("reset_last", oif.out_last, 0);
               read_start = 1'b0;
               @(negedge clk);
               reset = 1'b0;
               fin = 1;
            end else begin
               prev_stall = oif.out_valid && !oif.out_ready;
               pd = oif.out_data;
               pi = oif.out_idx;
               pl = oif.out_last;
               if (oif.out_valid && oif.out_ready) begin
                  check("out_data", oif.out_data, nat[nx]);
                  check("out_idx", oif.out_idx, nx);
                  check("out_last", oif.out_last, (nx == 255) ? 1 : 0);
                  check("range_err_drain", range_err, exp_range);
                  if (first_c < 0) first_c = c;
                  last_c = c;
                  nx++;
               end
               @(negedge clk);
            end
         end
      end
      if (!fin) check("burst_timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1;
      read_start = 1'b0;
      core_dout = '0;
      oif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", oif.out_valid, 0);
      check("rst_data", oif.out_data, 0);
      check("rst_idx", oif.out_idx, 0);
      check("rst_last", oif.out_last, 0);
      check("rst_range_err", range_err, 0);
      check("rst_start_err", start_err, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      // Ramp with consumer always ready
      for (int i = 0; i < 256; i++) nat[i] = i;
      burst(100, -1, -1, 0);
      idle(4);

      // Same ramp under random back-pressure
      burst(50, -1, -1, 0);
      idle(4);

      // Arrival word 5 (natural index 6) sits exactly at q
      for (int i = 0; i < 256; i++) nat[i] = $urandom_range(0, 3328);
      nat[6] = 3329;
      burst(100, -1, -1, 1);
      idle(2);

      // Restart while capturing; q-1 must not raise range_err
      for (int i = 0; i < 256; i++) nat[i] = $urandom_range(0, 3328);
      nat[100] = 3328;
      burst(70, 103, -1, 0);
      idle(2);

      // Back-to-back: second start lands in the done cycle
      for (int i = 0; i < 256; i++) nat[i] = i;
      burst(100, -1, -1, 0);
      for (int i = 0; i < 256; i++) nat[i] = 255 - i;
      burst(100, -1, -1, 0);
      idle(2);

      // Reset at drain transfer 40, then a clean ramp
      for (int i = 0; i < 256; i++) nat[i] = i;
      burst(100, -1, 40, 0);
      idle(2);
      burst(60, -1, -1, 0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
